// File: rtl/adc_seq_pkg.sv
// Shared types, default sizing and helpers for the SAR ADC conversion sequencer.
package adc_seq_pkg;

  localparam int unsigned RES_BITS_DEF = 12;
  localparam int unsigned CFG_BITS_DEF = 8;
  localparam int unsigned MAX_AVG_DEF  = 4;
  localparam int unsigned TMO_CYC_DEF  = 1024;
  localparam int unsigned IVL_W_DEF    = 16;

  typedef enum logic [2:0] {
    StIdle,
    StCfg,
    StStart,
    StWait,
    StRead,
    StGap
  } seq_state_e;

  function automatic logic [2:0] clamp_avg(input logic [2:0] avg, input int unsigned max_avg);
    if (32'(avg) > max_avg) begin
      clamp_avg = max_avg[2:0];
    end else begin
      clamp_avg = avg;
    end
  endfunction

endpackage

// File: rtl/adc_serial_shifter.sv
// Shift register shared by config output and result input; MSB leaves first,
// serial input enters at the LSB end.
module adc_serial_shifter #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] last_bit,
  input  logic [WIDTH-1:0] par_in,
  input  logic             sdi,
  output logic             sdo,
  output logic             active,
  output logic             done,
  output logic [WIDTH-1:0] par_out
);

  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      shreg_q  <= par_in;
      cnt_q    <= last_bit;
      active_q <= 1'b1;
    end else if (active_q) begin
      shreg_q <= {shreg_q[WIDTH-2:0], sdi};
      cnt_q   <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end
    end
  end

  assign sdo     = shreg_q[WIDTH-1];
  assign active  = active_q;
  assign done    = active_q & (cnt_q == '0);
  // Includes the bit being sampled this cycle, so the word is complete on done.
  assign par_out = {shreg_q[WIDTH-2:0], sdi};

endmodule

// File: rtl/adc_conv_sequencer.sv
// Sequencer for the SAR ADC macro: config load, conversion starts, serial result
// readout, 2^n averaging and a valid/ready result port with sticky error flags.
module adc_conv_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned RES_BITS = RES_BITS_DEF,
  parameter int unsigned CFG_BITS = CFG_BITS_DEF,
  parameter int unsigned MAX_AVG  = MAX_AVG_DEF,
  parameter int unsigned TMO_CYC  = TMO_CYC_DEF,
  parameter int unsigned IVL_W    = IVL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                single,
  input  logic                go,
  input  logic [CFG_BITS-1:0] cfg_word,
  input  logic                cfg_upd,
  input  logic [2:0]          avg_log2,
  input  logic [IVL_W-1:0]    interval,
  output logic                adc_conv_start,
  input  logic                adc_conv_finish,
  output logic                adc_load,
  output logic                adc_dati,
  input  logic                adc_dato,
  output logic [RES_BITS-1:0] res_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                overrun,
  output logic                timeout,
  input  logic                clr_flags,
  output logic                busy
);

  localparam int unsigned SH_W    = (RES_BITS > CFG_BITS) ? RES_BITS : CFG_BITS;
  localparam int unsigned CNT_W   = $clog2(SH_W);
  localparam int unsigned ACC_W   = RES_BITS + MAX_AVG;
  localparam int unsigned SCNT_W  = MAX_AVG + 1;
  localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);

  seq_state_e          state_q;
  logic                cfg_pend_q;
  logic                cfg_run_q;
  logic                busy_q;
  logic                conv_start_q;
  logic                fin_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [IVL_W-1:0]    gap_q;
  logic [2:0]          avg_q;
  logic [SCNT_W-1:0]   samp_cnt_q;
  logic [ACC_W-1:0]    acc_q;
  logic [RES_BITS-1:0] res_data_q;
  logic                res_valid_q;
  logic                overrun_q;
  logic                timeout_q;

  logic                sh_load;
  logic [CNT_W-1:0]    sh_last;
  logic [SH_W-1:0]     sh_par_in;
  logic                sh_sdo;
  logic                sh_active;
  logic                sh_done;
  logic [SH_W-1:0]     sh_par_out;

  logic                fin_rise;
  logic                cfg_load;
  logic                rd_load;
  logic [ACC_W-1:0]    acc_sum;
  logic [SCNT_W-1:0]   samp_nxt;
  logic                win_done;
  logic [RES_BITS-1:0] res_new;
  logic                new_res;
  logic                hs;

  always_comb begin
    fin_rise  = adc_conv_finish & ~fin_q;
    cfg_load  = (state_q == StCfg) & ~cfg_run_q;
    rd_load   = (state_q == StWait) & fin_rise;
    sh_load   = cfg_load | rd_load;
    sh_last   = (state_q == StCfg) ? CNT_W'(CFG_BITS - 1) : CNT_W'(RES_BITS - 1);
    // Config word is left-aligned so its MSB is the first bit out.
    sh_par_in = SH_W'(cfg_word) << (SH_W - CFG_BITS);
    acc_sum   = acc_q + ACC_W'(RES_BITS'(sh_par_out));
    samp_nxt  = samp_cnt_q + 1'b1;
    win_done  = samp_nxt >= (SCNT_W'(1) << avg_q);
    res_new   = RES_BITS'(acc_sum >> avg_q);
    new_res   = (state_q == StRead) & sh_done & win_done;
    hs        = res_valid_q & res_ready;
  end

  adc_serial_shifter #(
    .WIDTH (SH_W),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .last_bit (sh_last),
    .par_in   (sh_par_in),
    .sdi      (adc_dato),
    .sdo      (sh_sdo),
    .active   (sh_active),
    .done     (sh_done),
    .par_out  (sh_par_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StCfg;
      cfg_pend_q   <= 1'b1;
      cfg_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      conv_start_q <= 1'b0;
      fin_q        <= 1'b0;
      tmo_q        <= '0;
      gap_q        <= '0;
      avg_q        <= '0;
      samp_cnt_q   <= '0;
      acc_q        <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      fin_q        <= adc_conv_finish;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b1;
      if (cfg_upd) begin
        cfg_pend_q <= 1'b1;
      end
      // Flag sets below are later in the block, so a same-cycle set beats the clear.
      if (clr_flags) begin
        overrun_q <= 1'b0;
        timeout_q <= 1'b0;
      end

      if (new_res) begin
        if (res_valid_q & ~res_ready) begin
          overrun_q <= 1'b1;
        end else begin
          res_data_q  <= res_new;
          res_valid_q <= 1'b1;
        end
      end else if (hs) begin
        res_valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (cfg_pend_q) begin
            state_q <= StCfg;
          end else if (enable & (go | ~single | (samp_cnt_q != '0))) begin
            // A window interrupted by a config reload resumes without a new go.
            state_q      <= StStart;
            conv_start_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        StCfg: begin
          if (cfg_load) begin
            cfg_run_q  <= 1'b1;
            cfg_pend_q <= cfg_upd;
          end else if (sh_done) begin
            cfg_run_q <= 1'b0;
            state_q   <= StIdle;
            busy_q    <= 1'b0;
          end
        end
        StStart: begin
          tmo_q <= TMO_W'(TMO_CYC);
          if (samp_cnt_q == '0) begin
            avg_q <= clamp_avg(avg_log2, MAX_AVG);
          end
          state_q <= StWait;
        end
        StWait: begin
          if (fin_rise) begin
            state_q <= StRead;
          end else if (tmo_q <= TMO_W'(1)) begin
            timeout_q  <= 1'b1;
            acc_q      <= '0;
            samp_cnt_q <= '0;
            state_q    <= StIdle;
            busy_q     <= 1'b0;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        StRead: begin
          if (sh_done) begin
            gap_q <= interval;
            if (win_done) begin
              acc_q      <= '0;
              samp_cnt_q <= '0;
              if (single) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end else begin
                state_q <= StGap;
              end
            end else begin
              acc_q      <= acc_sum;
              samp_cnt_q <= samp_nxt;
              state_q    <= StGap;
            end
          end
        end
        StGap: begin
          if (~enable | cfg_pend_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (gap_q <= IVL_W'(1)) begin
            state_q      <= StStart;
            conv_start_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign adc_conv_start = conv_start_q;
  assign adc_load       = sh_active;
  assign adc_dati       = sh_sdo & (state_q == StCfg);
  assign res_data       = res_data_q;
  assign res_valid      = res_valid_q;
  assign overrun        = overrun_q;
  assign timeout        = timeout_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer with a behavioural SAR ADC macro model.
module tb_adc_conv_sequencer;

  localparam int TCONV = 5;
  localparam int TMO   = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        single;
  logic        go;
  logic [7:0]  cfg_word;
  logic        cfg_upd;
  logic [2:0]  avg_log2;
  logic [15:0] interval;
  logic        adc_conv_start;
  logic        adc_conv_finish;
  logic        adc_load;
  logic        adc_dati;
  logic        adc_dato;
  logic [11:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        overrun;
  logic        timeout;
  logic        clr_flags;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // ADC model state
  logic [11:0] samp_mem [16];
  logic [11:0] cur_samp;
  int          samp_rd = 0;
  int          n_starts = 0;
  int          start_cyc [8];
  int          m_timer = 0;
  bit          hang = 1'b0;
  bit          rd_armed = 1'b0;
  int          rd_idx = 0;
  logic [7:0]  cfg_cap = 8'h00;
  int          cfg_bits = 0;
  int          cfg_at_start = -1;

  adc_conv_sequencer #(
    .RES_BITS (12),
    .CFG_BITS (8),
    .MAX_AVG  (4),
    .TMO_CYC  (TMO),
    .IVL_W    (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .single          (single),
    .go              (go),
    .cfg_word        (cfg_word),
    .cfg_upd         (cfg_upd),
    .avg_log2        (avg_log2),
    .interval        (interval),
    .adc_conv_start  (adc_conv_start),
    .adc_conv_finish (adc_conv_finish),
    .adc_load        (adc_load),
    .adc_dati        (adc_dati),
    .adc_dato        (adc_dato),
    .res_data        (res_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .overrun         (overrun),
    .timeout         (timeout),
    .clr_flags       (clr_flags),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC macro: finish rises TCONV clocks after start; bits are presented MSB first
  // while adc_load is high after a finish, otherwise adc_dati is captured as config.
  initial begin
    adc_conv_finish = 1'b0;
    adc_dato        = 1'b0;
    cur_samp        = 12'h000;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_timer         = 0;
        adc_conv_finish = 1'b0;
        rd_armed        = 1'b0;
        rd_idx          = 0;
      end else begin
        if (adc_conv_start) begin
          if (n_starts < 8) start_cyc[n_starts] = cyc;
          n_starts        = n_starts + 1;
          adc_conv_finish = 1'b0;
          cur_samp        = samp_mem[samp_rd % 16];
          samp_rd         = samp_rd + 1;
          m_timer         = TCONV;
        end else if (m_timer > 0) begin
          m_timer = m_timer - 1;
          if (m_timer == 0 && !hang) begin
            adc_conv_finish = 1'b1;
            rd_armed        = 1'b1;
            rd_idx          = 0;
          end
        end
        if (adc_load && rd_armed) begin
          adc_dato = cur_samp[11 - rd_idx];
          rd_idx   = rd_idx + 1;
          if (rd_idx == 12) rd_armed = 1'b0;
        end else if (adc_load) begin
          cfg_cap  = {cfg_cap[6:0], adc_dati};
          cfg_bits = cfg_bits + 1;
          if (cfg_bits == 8) cfg_at_start = n_starts;
        end
      end
    end
  end

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_word = 8'hA5;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({adc_load, busy, res_valid, adc_conv_start, overrun, timeout, adc_dati} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {adc_load, busy, res_valid, adc_conv_start, overrun, timeout, adc_dati});
    end
    n_checks++;
    if (res_data !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_data: got %h want 000", res_data);
    end
    cfg_bits = 0;
    rst = 1'b0;
    for (int i = 0; i < 40 && !(cfg_bits == 8 && busy == 1'b0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (cfg_bits != 8) begin
      n_errors++;
      $display("FAIL cfg_len: got %0d load clks want 8", cfg_bits);
    end
    n_checks++;
    if (cfg_cap !== 8'hA5) begin
      n_errors++;
      $display("FAIL cfg_bits: got %h want a5", cfg_cap);
    end
    n_checks++;
    if ({busy, adc_load} !== 2'b00) begin
      n_errors++;
      $display("FAIL cfg_idle: busy,load got %b want 00", {busy, adc_load});
    end
  endtask

  task automatic test_single();
    samp_mem[0] = 12'h5C3;
    samp_rd = 0;
    n_starts = 0;
    single = 1'b1;
    avg_log2 = 3'd0;
    interval = 16'd2;
    enable = 1'b1;
    pulse_go();
    for (int i = 0; i < 60 && res_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 12'h5C3) begin
      n_errors++;
      $display("FAIL single_result: valid=%b data=%h want 1/5c3", res_valid, res_data);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || busy !== 1'b0 || n_starts != 1) begin
      n_errors++;
      $display("FAIL single_hold: valid=%b busy=%b starts=%0d want 1/0/1",
               res_valid, busy, n_starts);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_handshake: valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_average();
    samp_mem[0] = 12'd100;
    samp_mem[1] = 12'd101;
    samp_mem[2] = 12'd102;
    samp_mem[3] = 12'd104;
    samp_rd = 0;
    n_starts = 0;
    avg_log2 = 3'd2;
    interval = 16'd3;
    pulse_go();
    for (int i = 0; i < 10 && n_starts < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    avg_log2 = 3'd0;
    for (int i = 0; i < 200 && res_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 12'd101) begin
      n_errors++;
      $display("FAIL avg_result: valid=%b data=%0d want 1/101", res_valid, res_data);
    end
    // START 1 + WAIT TCONV + READ 12 + GAP interval
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (start_cyc[i] - start_cyc[i-1] != 21) begin
        n_errors++;
        $display("FAIL avg_spacing%0d: got %0d clks want 21", i, start_cyc[i] - start_cyc[i-1]);
      end
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if (n_starts != 4 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL avg_stop: starts=%0d busy=%b want 4/0", n_starts, busy);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_overrun();
    samp_mem[0] = 12'h111;
    samp_mem[1] = 12'h222;
    samp_mem[2] = 12'h333;
    samp_mem[3] = 12'h444;
    samp_mem[4] = 12'h555;
    samp_rd = 0;
    n_starts = 0;
    @(negedge clk);
    avg_log2 = 3'd0;
    interval = 16'd0;
    res_ready = 1'b0;
    single = 1'b0;
    for (int i = 0; i < 60 && res_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 12'h111 || overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_first: valid=%b data=%h ovr=%b want 1/111/0", res_valid, res_data, overrun);
    end
    for (int i = 0; i < 60 && overrun !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (overrun !== 1'b1 || res_data !== 12'h111 || res_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL ovr_set: ovr=%b data=%h valid=%b want 1/111/1", overrun, res_data, res_valid);
    end
    n_checks++;
    if (start_cyc[1] - start_cyc[0] != 19) begin
      n_errors++;
      $display("FAIL ovr_b2b: got %0d clks want 19", start_cyc[1] - start_cyc[0]);
    end
    enable = 1'b0;
    for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_clear: ovr=%b busy=%b want 0/0", overrun, busy);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_drain: valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_timeout();
    int t0;
    hang = 1'b1;
    n_starts = 0;
    single = 1'b1;
    enable = 1'b1;
    pulse_go();
    for (int i = 0; i < 10 && n_starts < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    t0 = start_cyc[0];
    for (int i = 0; i < 1100 && timeout !== 1'b1; i++) @(negedge clk);
    // START is one clock, WAIT lasts TMO clocks, the flag registers at its end.
    n_checks++;
    if (timeout !== 1'b1 || cyc - t0 != TMO + 1) begin
      n_errors++;
      $display("FAIL tmo_set: timeout=%b after %0d clks want 1 after %0d", timeout, cyc - t0, TMO + 1);
    end
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || n_starts != 1) begin
      n_errors++;
      $display("FAIL tmo_idle: busy=%b valid=%b starts=%0d want 0/0/1", busy, res_valid, n_starts);
    end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    n_checks++;
    if (timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_clear: timeout=%b want 0", timeout);
    end
    hang = 1'b0;
  endtask

  task automatic test_abort_and_reload();
    samp_mem[0] = 12'hABC;
    samp_rd = 0;
    n_starts = 0;
    avg_log2 = 3'd0;
    pulse_go();
    for (int i = 0; i < 40 && !(adc_load === 1'b1 && rd_armed); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    cfg_word = 8'h3C;
    cfg_bits = 0;
    @(negedge clk);
    n_checks++;
    if ({adc_load, busy, res_valid, adc_conv_start, overrun, timeout} !== 6'b0
        || res_data !== 12'h000) begin
      n_errors++;
      $display("FAIL abort_outputs: ctrl=%b data=%h want 000000/000",
               {adc_load, busy, res_valid, adc_conv_start, overrun, timeout}, res_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40 && !(cfg_bits == 8 && busy == 1'b0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_checks++;
    if (cfg_cap !== 8'h3C || res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_reload: cfg=%h valid=%b want 3c/0", cfg_cap, res_valid);
    end

    samp_mem[0] = 12'h200;
    samp_mem[1] = 12'h301;
    samp_rd = 0;
    n_starts = 0;
    avg_log2 = 3'd1;
    interval = 16'd1;
    pulse_go();
    for (int i = 0; i < 10 && n_starts < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    cfg_word = 8'h5A;
    cfg_bits = 0;
    cfg_at_start = -1;
    cfg_upd = 1'b1;
    @(negedge clk);
    cfg_upd = 1'b0;
    for (int i = 0; i < 200 && res_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 12'h280) begin
      n_errors++;
      $display("FAIL upd_avg: valid=%b data=%h want 1/280", res_valid, res_data);
    end
    n_checks++;
    if (cfg_cap !== 8'h5A || cfg_bits != 8 || cfg_at_start != 1 || n_starts != 2) begin
      n_errors++;
      $display("FAIL upd_cfg: cfg=%h bits=%0d at_start=%0d starts=%0d want 5a/8/1/2",
               cfg_cap, cfg_bits, cfg_at_start, n_starts);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    single = 1'b1;
    go = 1'b0;
    cfg_word = 8'h00;
    cfg_upd = 1'b0;
    avg_log2 = 3'd0;
    interval = 16'd0;
    res_ready = 1'b0;
    clr_flags = 1'b0;
    for (int i = 0; i < 16; i++) samp_mem[i] = 12'hFFF;
    test_reset();
    test_single();
    test_average();
    test_overrun();
    test_timeout();
    test_abort_and_reload();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
